lsu: RTL and testbench

- Memory stage of the in-order pipeline. It sits between the execute stage (upstream) and the writeback stage (downstream).
- Accepts one instruction at a time over a valid/ready handshake.
- Loads and stores run as AXI4-Lite single-beat master transactions. Loads are lane-extracted and sign/zero-extended.
- Results are presented to writeback with `this_valid`, held stable until `next_ready`. Non-memory instructions pass through in one cycle.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu.sv | 175 +++++++++++++++++
 tb/tb_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the memory stage.
package lsu_pkg;

  localparam int unsigned DATA_BUS = 32;
  localparam int unsigned ADDR_BUS = 32;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // funct3 access size / sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Instruction fields captured on accept
  typedef struct packed {
    logic [ADDR_BUS-1:0] addr;
    logic [DATA_BUS-1:0] store_data;
    logic [2:0]          funct3;
    logic                reg_wen;
    logic [1:0]          wdata_sel;
    logic [DATA_BUS-1:0] csr_rdata;
  } ex_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling: load extract/extend and store data/strobe replication.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [DATA_BUS-1:0]   i_rdata,
  input  logic [1:0]            i_off,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_BUS-1:0]   i_store_data,
  output logic [DATA_BUS-1:0]   o_load_data,
  output logic [DATA_BUS-1:0]   o_wdata,
  output logic [DATA_BUS/8-1:0] o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword lane ignores off[0]: misaligned halves are silently aligned down
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Load extraction with sign or zero extension
  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Store data replicated across lanes; strobe selects the addressed lanes
  always_comb begin
    o_wdata = i_store_data;
    o_wstrb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_wstrb = 4'b0001 << i_off;
      end
      2'b01: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_wstrb = 4'b0011 << {i_off[1], 1'b0};
      end
      default: begin
        o_wdata = i_store_data;
        o_wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory stage: AXI4-Lite single-beat loads/stores with valid/ready toward writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_BUS,
  parameter int unsigned DATA_WIDTH = DATA_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prev_valid,
  output logic                    this_ready,
  input  logic [DATA_WIDTH-1:0]   ex_alu_result,
  input  logic [DATA_WIDTH-1:0]   ex_store_data,
  input  logic                    ex_mem_ren,
  input  logic                    ex_mem_wen,
  input  logic [2:0]              ex_funct3,
  input  logic                    ex_reg_wen,
  input  logic [1:0]              ex_reg_wdata_sel,
  input  logic [DATA_WIDTH-1:0]   ex_csr_rdata,
  output logic                    this_valid,
  input  logic                    next_ready,
  output logic                    wb_reg_wen,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic [DATA_WIDTH-1:0]   alu_result,
  output logic [1:0]              reg_wdata_sel,
  output logic [DATA_WIDTH-1:0]   csr_rdata,
  output logic                    bus_err,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  logic [2:0]            r_state;
  logic [2:0]            w_state_n;
  logic [2:0]            w_accept_state;
  ex_req_t               r_req;
  logic [DATA_WIDTH-1:0] r_dmem_rdata;
  logic                  r_bus_err;
  logic                  r_aw_done;
  logic                  r_w_done;

  logic                  w_accept;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_wstrb;

  lsu_align u_align (
    .i_rdata      (rdata),
    .i_off        (r_req.addr[1:0]),
    .i_funct3     (r_req.funct3),
    .i_store_data (r_req.store_data),
    .o_load_data  (w_load_data),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb)
  );

  assign this_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & next_ready);
  assign w_accept   = prev_valid & this_ready;

  // Request/valid outputs are pure state decodes so they cannot glitch or drop early
  assign arvalid    = (r_state == ST_RADDR);
  assign rready     = (r_state == ST_RDATA);
  assign awvalid    = (r_state == ST_WRITE) & ~r_aw_done;
  assign wvalid     = (r_state == ST_WRITE) & ~r_w_done;
  assign bready     = (r_state == ST_WRESP);
  assign this_valid = (r_state == ST_DONE);

  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rready & rvalid;
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_b_hs  = bready & bvalid;

  assign araddr = {r_req.addr[ADDR_WIDTH-1:2], 2'b00};
  assign awaddr = {r_req.addr[ADDR_WIDTH-1:2], 2'b00};
  assign wdata  = (r_state == ST_WRITE) ? w_wdata : '0;
  assign wstrb  = (r_state == ST_WRITE) ? w_wstrb : '0;

  assign wb_reg_wen    = r_req.reg_wen;
  assign alu_result    = r_req.addr;
  assign reg_wdata_sel = r_req.wdata_sel;
  assign csr_rdata     = r_req.csr_rdata;
  assign dmem_rdata    = r_dmem_rdata;
  assign bus_err       = r_bus_err;

  // Load wins when both ren and wen are set
  assign w_accept_state = ex_mem_ren ? ST_RADDR : (ex_mem_wen ? ST_WRITE : ST_DONE);

  // Next-state decode
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_n = w_accept_state;
      ST_RADDR: if (w_ar_hs) w_state_n = ST_RDATA;
      ST_RDATA: if (w_r_hs) w_state_n = ST_DONE;
      ST_WRITE: if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_n = ST_WRESP;
      ST_WRESP: if (w_b_hs) w_state_n = ST_DONE;
      ST_DONE: begin
        if (w_accept)        w_state_n = w_accept_state;
        else if (next_ready) w_state_n = ST_IDLE;
      end
      default:  w_state_n = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  // Capture instruction fields on accept; they stay frozen until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.addr       <= ex_alu_result;
      r_req.store_data <= ex_store_data;
      r_req.funct3     <= ex_funct3;
      r_req.reg_wen    <= ex_reg_wen;
      r_req.wdata_sel  <= ex_reg_wdata_sel;
      r_req.csr_rdata  <= ex_csr_rdata;
    end
  end

  // Load result and bus error, cleared per entry so non-loads deliver zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmem_rdata <= '0;
      r_bus_err    <= 1'b0;
    end else if (w_accept) begin
      r_dmem_rdata <= '0;
      r_bus_err    <= 1'b0;
    end else if (w_r_hs) begin
      r_dmem_rdata <= w_load_data;
      r_bus_err    <= (rresp != RESP_OKAY);
    end else if (w_b_hs) begin
      r_bus_err    <= (bresp != RESP_OKAY);
    end
  end

  // AW and W channels complete independently; track each handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_accept) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WRITE) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table plus scoreboard queue, with hand sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prev_valid, this_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        ex_mem_ren, ex_mem_wen;
  logic [2:0]  ex_funct3;
  logic        ex_reg_wen;
  logic [1:0]  ex_reg_wdata_sel;
  logic [31:0] ex_csr_rdata;
  logic        this_valid, next_ready, wb_reg_wen;
  logic [31:0] dmem_rdata, alu_result, csr_rdata;
  logic [1:0]  reg_wdata_sel;
  logic        bus_err;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .prev_valid(prev_valid), .this_ready(this_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_funct3(ex_funct3),
    .ex_reg_wen(ex_reg_wen), .ex_reg_wdata_sel(ex_reg_wdata_sel),
    .ex_csr_rdata(ex_csr_rdata),
    .this_valid(this_valid), .next_ready(next_ready),
    .wb_reg_wen(wb_reg_wen), .dmem_rdata(dmem_rdata), .alu_result(alu_result),
    .reg_wdata_sel(reg_wdata_sel), .csr_rdata(csr_rdata), .bus_err(bus_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdat;
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [31:0] exp_dmem;
    logic        exp_err;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  typedef struct packed {
    logic [31:0] dmem;
    logic [31:0] alu;
    logic [31:0] csr;
    logic        err;
    logic        wen;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Wait (bounded) for a result, pop the oldest expectation and compare
  task automatic collect(input string tag);
    exp_t e;
    int   n = 0;
    while (!this_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_timeout"}, {31'b0, this_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_dmem"}, dmem_rdata, e.dmem);
      chk({tag, "_alu"}, alu_result, e.alu);
      chk({tag, "_err"}, {31'b0, bus_err}, {31'b0, e.err});
      chk({tag, "_wen"}, {31'b0, wb_reg_wen}, {31'b0, e.wen});
      chk({tag, "_sel"}, {30'b0, reg_wdata_sel}, {30'b0, e.sel});
      chk({tag, "_csr"}, csr_rdata, e.csr);
    end
  endtask

  task automatic drive_ex(input vec_t v, input int idx);
    logic [31:0] t;
    exp_t        e;
    t                = idx;
    prev_valid       = 1'b1;
    ex_alu_result    = v.addr;
    ex_store_data    = v.sdata;
    ex_mem_ren       = v.ren;
    ex_mem_wen       = v.wen;
    ex_funct3        = v.f3;
    ex_reg_wen       = t[0];
    ex_reg_wdata_sel = t[2:1];
    ex_csr_rdata     = 32'hC500_0000 | t;
    e.dmem = v.exp_dmem;
    e.alu  = v.addr;
    e.csr  = 32'hC500_0000 | t;
    e.err  = v.exp_err;
    e.wen  = t[0];
    e.sel  = t[2:1];
    sb_q.push_back(e);
  endtask

  // Runs one vector end to end; called and returns at a negedge
  task automatic do_op(input vec_t v, input int idx);
    string       tag;
    int          n;
    int          k;
    logic        aw_done;
    logic        w_done;
    logic [31:0] exp_araddr;
    tag = $sformatf("v%0d", idx);
    exp_araddr = {v.addr[31:2], 2'b00};
    drive_ex(v, idx);
    #1;
    n = 0;
    while (!this_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, {31'b0, this_ready}, 32'd1);
    @(negedge clk);
    prev_valid = 1'b0;
    if (v.ren) begin
      for (k = 0; k <= v.ar_dly; k++) begin
        chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'd1);
        chk({tag, "_araddr"}, araddr, exp_araddr);
        chk({tag, "_no_aw"}, {31'b0, awvalid}, 32'd0);
        arready = (k == v.ar_dly);
        @(negedge clk);
      end
      arready = 1'b0;
      chk({tag, "_ar_drop"}, {31'b0, arvalid}, 32'd0);
      chk({tag, "_rready"}, {31'b0, rready}, 32'd1);
      rvalid = 1'b1;
      rdata  = v.rdat;
      rresp  = v.resp;
      @(negedge clk);
      rvalid = 1'b0;
    end else if (v.wen) begin
      aw_done = 1'b0;
      w_done  = 1'b0;
      k = 0;
      while (!(aw_done && w_done) && k < 20) begin
        chk({tag, "_awvalid"}, {31'b0, awvalid}, {31'b0, ~aw_done});
        chk({tag, "_wvalid"}, {31'b0, wvalid}, {31'b0, ~w_done});
        chk({tag, "_bready_early"}, {31'b0, bready}, 32'd0);
        if (awvalid) chk({tag, "_awaddr"}, awaddr, exp_araddr);
        if (wvalid) begin
          chk({tag, "_wdata"}, wdata, v.exp_wdata);
          chk({tag, "_wstrb"}, {28'b0, wstrb}, {28'b0, v.exp_wstrb});
        end
        awready = (k >= v.aw_dly);
        wready  = (k >= v.w_dly);
        if (awvalid && awready) aw_done = 1'b1;
        if (wvalid && wready) w_done = 1'b1;
        @(negedge clk);
        k++;
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (k = 0; k <= v.b_dly; k++) begin
        chk({tag, "_bready"}, {31'b0, bready}, 32'd1);
        chk({tag, "_aw_idle"}, {30'b0, awvalid, wvalid}, 32'd0);
        chk({tag, "_no_valid_before_b"}, {31'b0, this_valid}, 32'd0);
        bvalid = (k == v.b_dly);
        bresp  = v.resp;
        @(negedge clk);
      end
      bvalid = 1'b0;
    end else begin
      chk({tag, "_latency1"}, {31'b0, this_valid}, 32'd1);
      chk({tag, "_no_axi"}, {30'b0, arvalid, awvalid}, 32'd0);
    end
    collect(tag);
    @(negedge clk);
    chk({tag, "_idle"}, {31'b0, this_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vec_t v;
    // ren wen f3 addr sdata rdata resp ar aw w b exp_dmem err exp_wdata exp_wstrb
    vecs[0]  = '{0, 0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0,
                 32'h0, 0, 32'h0, 4'h0};
    vecs[1]  = '{1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 2'b00, 3, 0, 0, 0,
                 32'hFFFF_FF80, 0, 32'h0, 4'h0};
    vecs[2]  = '{1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 2'b00, 0, 0, 0, 0,
                 32'h0000_0080, 0, 32'h0, 4'h0};
    vecs[3]  = '{1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 2'b00, 1, 0, 0, 0,
                 32'hFFFF_8001, 0, 32'h0, 4'h0};
    vecs[4]  = '{1, 0, 3'b101, 32'h8000_0003, 32'h0, 32'h8001_7FFF, 2'b00, 0, 0, 0, 0,
                 32'h0000_8001, 0, 32'h0, 4'h0};
    vecs[5]  = '{1, 0, 3'b001, 32'h8000_0000, 32'h0, 32'h8001_7FFF, 2'b00, 0, 0, 0, 0,
                 32'h0000_7FFF, 0, 32'h0, 4'h0};
    vecs[6]  = '{1, 0, 3'b010, 32'h8000_0005, 32'h0, 32'hDEAD_BEEF, 2'b00, 2, 0, 0, 0,
                 32'hDEAD_BEEF, 0, 32'h0, 4'h0};
    vecs[7]  = '{1, 0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 0,
                 32'h0000_0056, 0, 32'h0, 4'h0};
    vecs[8]  = '{0, 1, 3'b001, 32'h8000_0002, 32'hABCD_1234, 32'h0, 2'b00, 0, 0, 2, 1,
                 32'h0, 0, 32'h1234_1234, 4'b1100};
    vecs[9]  = '{0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'h0, 2'b00, 0, 2, 0, 0,
                 32'h0, 0, 32'hA5A5_A5A5, 4'b0010};
    vecs[10] = '{0, 1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 2'b00, 0, 1, 1, 2,
                 32'h0, 0, 32'hCAFE_F00D, 4'b1111};
    vecs[11] = '{1, 0, 3'b010, 32'h8000_0020, 32'h0, 32'h1122_3344, 2'b10, 0, 0, 0, 0,
                 32'h1122_3344, 1, 32'h0, 4'h0};
    vecs[12] = '{1, 0, 3'b010, 32'h8000_0024, 32'h0, 32'h5566_7788, 2'b00, 0, 0, 0, 0,
                 32'h5566_7788, 0, 32'h0, 4'h0};
    vecs[13] = '{0, 1, 3'b000, 32'h0000_0003, 32'h0000_007F, 32'h0, 2'b11, 0, 0, 0, 0,
                 32'h0, 1, 32'h7F7F_7F7F, 4'b1000};
    vecs[14] = '{1, 1, 3'b010, 32'h0000_0040, 32'h9999_9999, 32'h55AA_55AA, 2'b00, 0, 0, 0, 0,
                 32'h55AA_55AA, 0, 32'h0, 4'h0};
    vecs[15] = '{0, 1, 3'b001, 32'h0000_0100, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 0,
                 32'h0, 0, 32'hBEEF_BEEF, 4'b0011};

    prev_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_mem_ren = 0; ex_mem_wen = 0;
    ex_funct3 = 0; ex_reg_wen = 0; ex_reg_wdata_sel = 0; ex_csr_rdata = 0;
    next_ready = 1; arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valids", {26'b0, this_valid, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rst_this_ready", {31'b0, this_ready}, 32'd1);
    chk("rst_alu", alu_result, 32'd0);
    chk("rst_dmem", dmem_rdata, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) do_op(vecs[i], i);

    // Back-to-back ALU ops with writeback stalled for two cycles
    next_ready = 1'b0;
    v = vecs[0];
    v.addr = 32'h0000_0111;
    drive_ex(v, 20);
    @(negedge clk);
    v.addr = 32'h0000_0222;
    drive_ex(v, 21);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("b2b_stall_valid", {31'b0, this_valid}, 32'd1);
      chk("b2b_stall_alu", alu_result, 32'h0000_0111);
      chk("b2b_stall_ready", {31'b0, this_ready}, 32'd0);
      @(negedge clk);
    end
    next_ready = 1'b1;
    #1;
    chk("b2b_ready_comb", {31'b0, this_ready}, 32'd1);
    collect("b2b_first");
    @(negedge clk);
    prev_valid = 1'b0;
    chk("b2b_no_bubble", {31'b0, this_valid}, 32'd1);
    collect("b2b_second");
    @(negedge clk);
    chk("b2b_idle", {31'b0, this_valid}, 32'd0);

    // Reset while waiting in RDATA
    prev_valid = 1'b1; ex_mem_ren = 1'b1; ex_mem_wen = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h8000_0044;
    @(negedge clk);
    prev_valid = 1'b0;
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rstmid_rready", {31'b0, rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_drop", {29'b0, rready, arvalid, this_valid}, 32'd0);
    chk("rstmid_this_ready", {31'b0, this_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstrel_idle", {28'b0, this_valid, rready, arvalid, this_ready}, 32'd1);
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
